// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Pipeline instruction-fetch stage. It holds the PC, issues level-sensitive
//   read requests to instruction memory, and loads the IF/ID pipeline register
//   (instruction, PC+4, valid) that feeds decode. A one-entry skid buffer keeps
//   a word that memory returns while the hazard unit is stalling. Redirects
//   (taken branch, jump, RegToPC) take priority over stall and ack.
//
//   Bit ordering is [0:SIZE-1] with bit 0 the MSB. Arithmetic is unaffected,
//   because the vector value is the same as in a descending declaration.
//
// Configuration:
//   IF_STALL_COUNT_EN - when defined, adds stall_count_out, a saturating
//                       counter of cycles lost to stalls or memory wait.
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   asynchronous, active-high reset
//   stall_in        in   hazard unit hold request for IF/ID
//   redirect_in     in   load PC from redirect_pc_in and flush
//   redirect_pc_in  in   redirect target (two LSBs ignored)
//   imem_req_out    out  instruction memory read request (REQ state only)
//   imem_addr_out   out  fetch address, always equal to the PC
//   imem_ack_in     in   imem_data_in is valid this cycle
//   imem_data_in    in   instruction word from memory
//   instruction_out out  IF/ID instruction
//   nextPC_out      out  IF/ID PC+4 of that instruction
//   valid_out       out  IF/ID holds a real instruction (0 = bubble)
//   stall_count_out out  stall cycle counter (IF_STALL_COUNT_EN only)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                SIZE      = 32,
  parameter logic [0:SIZE-1]   RESET_PC  = 32'h00000000,
  parameter logic [0:SIZE-1]   NOP_INSTR = 32'h54000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [0:SIZE-1] redirect_pc_in,
  output logic            imem_req_out,
  output logic [0:SIZE-1] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [0:SIZE-1] imem_data_in,
  output logic [0:SIZE-1] instruction_out,
  output logic [0:SIZE-1] nextPC_out,
  output logic            valid_out
`ifdef IF_STALL_COUNT_EN
  ,
  output logic [0:SIZE-1] stall_count_out
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [0:SIZE-1] PC_INC = SIZE'(4);

  state_t          state_q, state_d;
  logic [0:SIZE-1] pc_q, pc_d;
  logic [0:SIZE-1] instr_q, instr_d;
  logic [0:SIZE-1] npc_q, npc_d;
  logic            valid_q, valid_d;
  logic [0:SIZE-1] skid_instr_q, skid_instr_d;
  logic [0:SIZE-1] skid_npc_q, skid_npc_d;
  logic            skid_valid_q, skid_valid_d;

  logic [0:SIZE-1] pc_plus4;
  logic [0:SIZE-1] redirect_pc_aligned;

  // Wraps modulo 2^SIZE naturally: the carry out of bit 0 is dropped.
  assign pc_plus4            = pc_q + PC_INC;
  assign redirect_pc_aligned = {redirect_pc_in[0:SIZE-3], 2'b00};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: the skid payload is reset along with its valid flag; it is only a
  // couple of words, and a defined value keeps X out of IF/ID on a bad path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      npc_q        <= '0;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_npc_q   <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      npc_q        <= npc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_npc_q   <= skid_npc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    npc_d        = npc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_npc_d   = skid_npc_q;
    skid_valid_d = skid_valid_q;

    unique case (state_q)
      IDLE: begin
        if (redirect_in) begin
          pc_d = redirect_pc_aligned;
        end
        state_d = REQ;
      end

      REQ: begin
        if (redirect_in) begin
          // Flush: any word acked this cycle belongs to the wrong path.
          pc_d         = redirect_pc_aligned;
          instr_d      = NOP_INSTR;
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          state_d      = REQ;
        end else if (imem_ack_in && !stall_in) begin
          instr_d = imem_data_in;
          npc_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else if (!imem_ack_in && !stall_in) begin
          // Memory still busy: decode sees a bubble, nextPC is left as is.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (imem_ack_in && stall_in) begin
          // IF/ID is frozen, so park the returned word until the stall drops.
          skid_instr_d = imem_data_in;
          skid_npc_d   = pc_plus4;
          skid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          state_d      = HOLD;
        end
        // ack=0, stall=1: everything holds.
      end

      HOLD: begin
        if (redirect_in) begin
          pc_d         = redirect_pc_aligned;
          instr_d      = NOP_INSTR;
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          state_d      = REQ;
        end else if (!stall_in) begin
          instr_d      = skid_instr_q;
          npc_d        = skid_npc_q;
          valid_d      = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request is a function of state only, so the address may move (on a
  // redirect) while no ack has arrived; memory must treat it as cancellable.
  assign imem_req_out    = (state_q == REQ);
  assign imem_addr_out   = pc_q;
  assign instruction_out = instr_q;
  assign nextPC_out      = npc_q;
  assign valid_out       = valid_q;

`ifdef IF_STALL_COUNT_EN
  // ---------------------------------------------------------------------------
  // Stall cycle counter: hazard stalls plus cycles waiting on memory.
  // ---------------------------------------------------------------------------
  logic [0:SIZE-1] stall_cnt_q, stall_cnt_d;
  logic            stall_cycle;

  assign stall_cycle = stall_in || ((state_q == REQ) && !imem_ack_in);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SIZE'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_out = stall_cnt_q;
`else
  // Counter and its port are absent in this build.
`endif

endmodule
